lfsr_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the shared `LFSR` pattern generator.
- On a start request it seeds the LFSR and steps it for a programmed number of patterns.
- Each cycle it compacts the device-under-test response into a multiple-input signature register (MISR), then compares the signature against a golden value and reports pass/fail.
- It sits between the test-control CSR block and the `LFSR` instance: it drives the LFSR's seed, load and enable inputs, and observes the LFSR output and the DUT response.

---
 rtl/lfsr_bist_ctrl.sv | 119 +++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer: seeds and steps the shared LFSR, compacts DUT responses into a MISR
// and compares the final signature against a golden value.
module lfsr_bist_ctrl #(
    parameter int unsigned      Width      = 4,
    parameter int unsigned      CountWidth = 8,
    parameter logic [Width-1:0] Taps       = 4'b1001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [Width-1:0]      seed,
    input  logic [CountWidth-1:0] count,
    input  logic [Width-1:0]      golden,
    input  logic [Width-1:0]      lfsr_q,
    input  logic [Width-1:0]      resp,
    output logic [Width-1:0]      lfsr_seed,
    output logic                  lfsr_load,
    output logic                  lfsr_enable,
    output logic                  pattern_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [Width-1:0]      signature
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCheck, StDone} state_e;

    state_e                state_q, state_d;
    logic [Width-1:0]      seed_q, seed_d;
    logic [Width-1:0]      golden_q, golden_d;
    logic [Width-1:0]      sig_q, sig_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  pass_q, pass_d;

    // The LFSR output is only watched by loopback benches, never used internally.
    logic unused_lfsr_q;
    assign unused_lfsr_q = ^lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            seed_q   <= '0;
            golden_q <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            golden_q <= golden_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        golden_d = golden_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    seed_d   = seed;
                    golden_d = golden;
                    cnt_d    = count;
                    pass_d   = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                sig_d   = '0;
                state_d = (cnt_q != '0) ? StRun : StCheck;
            end
            StRun: begin
                sig_d = {^(sig_q & Taps), sig_q[Width-1:1]} ^ resp;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CountWidth'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                pass_d  = (sig_q == golden_q);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort freezes the partial signature and counter; the abort-cycle response is dropped.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            pass_d  = 1'b0;
            sig_d   = sig_q;
            cnt_d   = cnt_q;
        end
    end

    always_comb begin
        lfsr_load     = (state_q == StLoad);
        lfsr_enable   = (state_q == StRun) && !abort;
        pattern_valid = (state_q == StRun) && !abort;
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        pass          = pass_q;
        signature     = sig_q;
        lfsr_seed     = seed_q;
    end

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl with a loopback LFSR (x^4 + x^3 + 1, shift right).
module tb_lfsr_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [3:0] seed, golden, lfsr_q, resp, lfsr_seed, signature;
    logic [7:0] count;
    logic       lfsr_load, lfsr_enable, pattern_valid, busy, done, pass;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int dc;
    bit en_seen;
    bit done_seen;

    always #5 clk = ~clk;

    lfsr_bist_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .seed         (seed),
        .count        (count),
        .golden       (golden),
        .lfsr_q       (lfsr_q),
        .resp         (resp),
        .lfsr_seed    (lfsr_seed),
        .lfsr_load    (lfsr_load),
        .lfsr_enable  (lfsr_enable),
        .pattern_valid(pattern_valid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    // Pattern generator: 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 1011 -> 0101 -> 1010 ...
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= '0;
        end else if (lfsr_load) begin
            lfsr_q <= lfsr_seed;
        end else if (lfsr_enable) begin
            lfsr_q <= {lfsr_q[3] ^ lfsr_q[0], lfsr_q[3:1]};
        end
    end

    assign resp = lfsr_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (lfsr_enable) en_seen = 1'b1;
        if (done) done_seen = 1'b1;
    endtask

    // Start is sampled at edge 0; on return we are in cycle 1.
    task automatic start_test(input logic [3:0] s, input logic [7:0] c, input logic [3:0] g);
        seed   = s;
        count  = c;
        golden = g;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cyc       = 1;
        en_seen   = 1'b0;
        done_seen = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        seed   = 4'h0;
        count  = 8'd0;
        golden = 4'h0;
        cyc    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_load", lfsr_load, 0);
        check_eq("rst_enable", lfsr_enable, 0);
        check_eq("rst_valid", pattern_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_sig", signature, 0);
        check_eq("rst_seed", lfsr_seed, 0);
        reset = 1'b0;
        step();

        // count=1 loopback
        start_test(4'b1000, 8'd1, 4'b1000);
        check_eq("c1_load", lfsr_load, 1);
        check_eq("c1_busy", busy, 1);
        check_eq("c1_enable_in_load", lfsr_enable, 0);
        wait_done(20, dc);
        check_eq("c1_done_cycle", dc, 4);
        check_eq("c1_sig", signature, 4'b1000);
        check_eq("c1_pass", pass, 1);
        step();
        check_eq("c1_busy_fall", busy, 0);
        check_eq("c1_done_pulse", done, 0);

        // count=2 loopback, matching golden
        start_test(4'b1000, 8'd2, 4'b0000);
        step();
        check_eq("c2_valid", pattern_valid, 1);
        check_eq("c2_pat0", lfsr_q, 4'b1000);
        step();
        check_eq("c2_pat1", lfsr_q, 4'b1100);
        wait_done(20, dc);
        check_eq("c2_done_cycle", dc, 5);
        check_eq("c2_sig", signature, 4'b0000);
        check_eq("c2_pass", pass, 1);
        step();

        // same test, wrong golden
        start_test(4'b1000, 8'd2, 4'b0001);
        wait_done(20, dc);
        check_eq("c2bad_done_cycle", dc, 5);
        check_eq("c2bad_pass", pass, 0);
        step();

        // count=0
        start_test(4'b1000, 8'd0, 4'b0000);
        wait_done(20, dc);
        check_eq("c0_done_cycle", dc, 3);
        check_eq("c0_enable_seen", en_seen, 0);
        check_eq("c0_pass", pass, 1);
        check_eq("c0_sig", signature, 0);
        step();

        // back-to-back: start in the first IDLE cycle after DONE
        start_test(4'b1000, 8'd1, 4'b1000);
        wait_done(20, dc);
        check_eq("b2b_a_pass", pass, 1);
        step();
        check_eq("b2b_idle", busy, 0);
        start_test(4'b1000, 8'd2, 4'b0001);
        check_eq("b2b_load", lfsr_load, 1);
        check_eq("b2b_pass_clr", pass, 0);
        wait_done(20, dc);
        check_eq("b2b_done_cycle", dc, 5);
        step();

        // abort at cycle 8 with an ignored start at cycle 5
        start_test(4'b1000, 8'd20, 4'b0000);
        repeat (4) step();
        check_eq("ab_pat_c5", lfsr_q, 4'b1111);
        seed  = 4'b0011;
        count = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        seed  = 4'b1000;
        check_eq("ab_seed_kept", lfsr_seed, 4'b1000);
        check_eq("ab_busy_c6", busy, 1);
        step();
        step();
        check_eq("ab_pat_c8", lfsr_q, 4'b0101);
        abort = 1'b1;
        #1;
        check_eq("ab_enable_gated", lfsr_enable, 0);
        check_eq("ab_valid_gated", pattern_valid, 0);
        step();
        abort = 1'b0;
        check_eq("ab_busy", busy, 0);
        check_eq("ab_pass", pass, 0);
        check_eq("ab_no_done", done_seen, 0);
        check_eq("ab_no_step", lfsr_q, 4'b0101);
        check_eq("ab_seed_after", lfsr_seed, 4'b1000);
        step();

        // reset mid-RUN
        start_test(4'b1000, 8'd50, 4'b0000);
        repeat (9) step();
        check_eq("rr_busy_c10", busy, 1);
        reset = 1'b1;
        step();
        check_eq("rr_busy", busy, 0);
        check_eq("rr_enable", lfsr_enable, 0);
        check_eq("rr_sig", signature, 0);
        check_eq("rr_pass", pass, 0);
        reset = 1'b0;
        step();
        start_test(4'b1000, 8'd1, 4'b1000);
        wait_done(20, dc);
        check_eq("rr_fresh_done", dc, 4);
        check_eq("rr_fresh_pass", pass, 1);
        check_eq("rr_fresh_sig", signature, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
